// File: rtl/sent_rx_frame_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sent_rx_frame_decoder                                                    |
// | SENT fast-channel receiver: tick timing, frame FSM, CRC4, output hold.   |
// | Option macro: SENT_RX_PAUSE_EN (accept a pause pulse after the CRC).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sent_rx_frame_decoder #(
   parameter int NIBBLES      = 6,
   parameter int CLK_PER_TICK = 3
) (
   input  logic                   clk_rx,
   input  logic                   reset_rx,
   input  logic                   data_pulse,
   input  logic                   frame_ready,
   output logic                   frame_valid,
   output logic [3:0]             frame_status,
   output logic [4*NIBBLES-1:0]   frame_data,
   output logic                   frame_crc_ok,
   output logic                   pulse_error,
   output logic                   overrun
);

   localparam int              PW       = $clog2(CLK_PER_TICK);
   localparam int              DW       = 4 * NIBBLES;
   localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_PER_TICK - 1);
   localparam logic [9:0]      TICK_MAX = 10'd1023;
   localparam logic [2:0]      IDX_LAST = 3'(NIBBLES - 1);
   localparam logic [3:0]      CRC_SEED = 4'h5;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HUNT   = 3'd1,
      S_STATUS = 3'd2,
      S_DATA   = 3'd3,
      S_CRC    = 3'd4,
      S_SYNC   = 3'd5
`ifdef SENT_RX_PAUSE_EN
      , S_PAUSE = 3'd6
`endif
   } state_t;

   function automatic logic [3:0] crc4_nibble(input logic [3:0] crc_in, input logic [3:0] nib);
      logic [3:0] c;
      logic       fb;
      c = crc_in;
      for (int b = 3; b >= 0; b--) begin
         fb = c[3] ^ nib[b];
         c  = {c[2:0], 1'b0} ^ (fb ? 4'hD : 4'h0);
      end
      return c;
   endfunction

   logic          sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [9:0]    tick_q, tick_d;
   state_t        state_q, state_d;
   logic [2:0]    idx_q, idx_d;
   logic [3:0]    status_w_q, status_w_d;
   logic [DW-1:0] data_w_q, data_w_d;
   logic [3:0]    crc_q, crc_d;
   logic          frame_valid_q, frame_valid_d;
   logic [3:0]    frame_status_q, frame_status_d;
   logic [DW-1:0] frame_data_q, frame_data_d;
   logic          frame_crc_ok_q, frame_crc_ok_d;
   logic          pulse_error_q, pulse_error_d;
   logic          overrun_q, overrun_d;

   logic          fall, wrap, nib_ok, sync_ok;
   logic [9:0]    period;
   logic [3:0]    nib_val;
   logic          go_error, frame_done;

   assign fall    = sync3_q & ~sync2_q;
   assign wrap    = (pre_q == PRE_LAST);
   // Period includes the tick completing on this very cycle, so an N-tick
   // pulse measures exactly N between falls.
   assign period  = (wrap && tick_q != TICK_MAX) ? tick_q + 10'd1 : tick_q;
   assign nib_ok  = (period >= 10'd12) && (period <= 10'd27);
   assign sync_ok = (period >= 10'd55) && (period <= 10'd57);
   assign nib_val = 4'(period - 10'd12);

   always_comb begin
      sync1_d        = data_pulse;
      sync2_d        = sync1_q;
      sync3_d        = sync2_q;
      pre_d          = wrap ? '0 : pre_q + PW'(1);
      tick_d         = period;
      state_d        = state_q;
      idx_d          = idx_q;
      status_w_d     = status_w_q;
      data_w_d       = data_w_q;
      crc_d          = crc_q;
      frame_valid_d  = frame_valid_q;
      frame_status_d = frame_status_q;
      frame_data_d   = frame_data_q;
      frame_crc_ok_d = frame_crc_ok_q;
      pulse_error_d  = 1'b0;
      overrun_d      = 1'b0;
      go_error       = 1'b0;
      frame_done     = 1'b0;

      if (fall) begin
         pre_d  = '0;
         tick_d = '0;
      end

      if (frame_valid_q && frame_ready)
         frame_valid_d = 1'b0;

      if (fall) begin
         case (state_q)
            S_IDLE: state_d = S_HUNT;
            S_HUNT: if (sync_ok) state_d = S_STATUS;
            S_STATUS: begin
               if (nib_ok) begin
                  status_w_d = nib_val;
                  idx_d      = '0;
                  crc_d      = CRC_SEED;
                  state_d    = S_DATA;
               end else begin
                  go_error = 1'b1;
               end
            end
            S_DATA: begin
               if (nib_ok) begin
                  data_w_d = DW'({data_w_q, nib_val});
                  crc_d    = crc4_nibble(crc_q, nib_val);
                  idx_d    = idx_q + 3'd1;
                  if (idx_q == IDX_LAST) state_d = S_CRC;
               end else begin
                  go_error = 1'b1;
               end
            end
            S_CRC: begin
               if (nib_ok) begin
                  frame_done = 1'b1;
                  state_d    = S_SYNC;
               end else begin
                  go_error = 1'b1;
               end
            end
            S_SYNC: begin
               if (sync_ok)
                  state_d = S_STATUS;
`ifdef SENT_RX_PAUSE_EN
               else if (period >= 10'd12 && period <= 10'd768)
                  state_d = S_PAUSE;
`endif
               else
                  go_error = 1'b1;
            end
`ifdef SENT_RX_PAUSE_EN
            S_PAUSE: begin
               if (sync_ok) state_d = S_STATUS;
               else         go_error = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end else if (tick_q == TICK_MAX && state_q != S_IDLE) begin
         // A silent line after a finished frame (or while hunting) is normal.
         state_d       = S_IDLE;
         pulse_error_d = (state_q != S_HUNT) && (state_q != S_SYNC);
      end

      if (go_error) begin
         pulse_error_d = 1'b1;
         state_d       = S_HUNT;
      end

      if (frame_done) begin
         if (!frame_valid_q || frame_ready) begin
            frame_valid_d  = 1'b1;
            frame_status_d = status_w_q;
            frame_data_d   = data_w_q;
            frame_crc_ok_d = (crc4_nibble(crc_q, 4'h0) == nib_val);
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_rx or posedge reset_rx) begin
      if (reset_rx) begin
         sync1_q        <= 1'b1;
         sync2_q        <= 1'b1;
         sync3_q        <= 1'b1;
         pre_q          <= '0;
         tick_q         <= '0;
         state_q        <= S_IDLE;
         idx_q          <= '0;
         status_w_q     <= '0;
         data_w_q       <= '0;
         crc_q          <= '0;
         frame_valid_q  <= 1'b0;
         frame_status_q <= '0;
         frame_data_q   <= '0;
         frame_crc_ok_q <= 1'b0;
         pulse_error_q  <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         sync3_q        <= sync3_d;
         pre_q          <= pre_d;
         tick_q         <= tick_d;
         state_q        <= state_d;
         idx_q          <= idx_d;
         status_w_q     <= status_w_d;
         data_w_q       <= data_w_d;
         crc_q          <= crc_d;
         frame_valid_q  <= frame_valid_d;
         frame_status_q <= frame_status_d;
         frame_data_q   <= frame_data_d;
         frame_crc_ok_q <= frame_crc_ok_d;
         pulse_error_q  <= pulse_error_d;
         overrun_q      <= overrun_d;
      end
   end

   assign frame_valid  = frame_valid_q;
   assign frame_status = frame_status_q;
   assign frame_data   = frame_data_q;
   assign frame_crc_ok = frame_crc_ok_q;
   assign pulse_error  = pulse_error_q;
   assign overrun      = overrun_q;

endmodule
`default_nettype wire
